// File: rtl/tp_video_source_if.sv
// Camera-style video bus: frame-valid, line-valid and pixel data.
// The master drives all three; the slave consumes them.
interface tp_video_source_if #(
    parameter int unsigned DATA_W = 12
);
    logic              oFValid;
    logic              oLValid;
    logic [DATA_W-1:0] odata;

    modport master (
        output oFValid,
        output oLValid,
        output odata
    );

    modport slave (
        input oFValid,
        input oLValid,
        input odata
    );
endinterface

// File: rtl/tp_video_source.sv
// Test-pattern video source: programmable frame timing with blanking and four
// selectable pixel patterns, driven onto the master end of the video bus.
module tp_video_source #(
    parameter int unsigned       DATA_W    = 12,
    parameter int unsigned       H_ACTIVE  = 640,
    parameter int unsigned       H_BLANK   = 16,
    parameter int unsigned       V_ACTIVE  = 480,
    parameter int unsigned       FV_LEAD   = 4,
    parameter int unsigned       FV_TRAIL  = 4,
    parameter int unsigned       V_BLANK   = 32,
    parameter logic [DATA_W-1:0] CONST_VAL = 'h800
) (
    input  logic               sig_clock,
    input  logic               sig_reset,
    input  logic               sig_en_i,
    input  logic [1:0]         pat_sel,
    output logic               sig_en_o,
    output logic [15:0]        frame_cnt,
    tp_video_source_if.master  vid
);

    localparam int unsigned Max1   = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
    localparam int unsigned Max2   = (FV_LEAD > FV_TRAIL) ? FV_LEAD : FV_TRAIL;
    localparam int unsigned Max3   = (Max1 > Max2) ? Max1 : Max2;
    localparam int unsigned MaxLen = (Max3 > V_BLANK) ? Max3 : V_BLANK;
    localparam int unsigned CntW   = $clog2(MaxLen + 1);
    localparam int unsigned RowW   = $clog2(V_ACTIVE + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StLine,
        StHblank,
        StTrail,
        StVblank
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [1:0]        pat_q, pat_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              fvalid_d, lvalid_d, busy_d;
    logic [DATA_W-1:0] data_d;

    function automatic logic [DATA_W-1:0] pixel(input logic [1:0] pat,
                                                input logic [CntW-1:0] col,
                                                input logic [RowW-1:0] row);
        logic [31:0] c;
        logic [31:0] r;
        c = 32'(col);
        r = 32'(row);
        case (pat)
            2'd0:    pixel = DATA_W'(c);
            2'd1:    pixel = DATA_W'(c + r);
            2'd2:    pixel = (c[3] ^ r[3]) ? '1 : '0;
            default: pixel = CONST_VAL;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = (state_q == StIdle) ? '0 : cnt_q + CntW'(1);
        row_d       = row_q;
        pat_d       = pat_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (sig_en_i) begin
                    state_d = StLead;
                    pat_d   = pat_sel;
                end
            end
            StLead: begin
                if (cnt_q == CntW'(FV_LEAD - 1)) begin
                    state_d = StLine;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            end
            StLine: begin
                if (cnt_q == CntW'(H_ACTIVE - 1)) begin
                    state_d = (row_q == RowW'(V_ACTIVE - 1)) ? StTrail : StHblank;
                    cnt_d   = '0;
                end
            end
            StHblank: begin
                if (cnt_q == CntW'(H_BLANK - 1)) begin
                    state_d = StLine;
                    cnt_d   = '0;
                    row_d   = row_q + RowW'(1);
                end
            end
            StTrail: begin
                if (cnt_q == CntW'(FV_TRAIL - 1)) begin
                    state_d     = StVblank;
                    cnt_d       = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            StVblank: begin
                if (cnt_q == CntW'(V_BLANK - 1)) begin
                    cnt_d = '0;
                    if (sig_en_i) begin
                        state_d = StLead;
                        pat_d   = pat_sel;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are computed from the next state so the bus pins come straight off flops.
        fvalid_d = (state_d != StIdle) && (state_d != StVblank);
        lvalid_d = (state_d == StLine);
        busy_d   = (state_d != StIdle);
        data_d   = lvalid_d ? pixel(pat_d, cnt_d, row_d) : '0;
    end

    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            row_q       <= '0;
            pat_q       <= '0;
            frame_cnt_q <= '0;
            sig_en_o    <= 1'b0;
            vid.oFValid <= 1'b0;
            vid.oLValid <= 1'b0;
            vid.odata   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            pat_q       <= pat_d;
            frame_cnt_q <= frame_cnt_d;
            sig_en_o    <= busy_d;
            vid.oFValid <= fvalid_d;
            vid.oLValid <= lvalid_d;
            vid.odata   <= data_d;
        end
    end

    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tp_video_source.sv
// Scoreboard bench for tp_video_source: stimulus queues expected pixels, negedge
// monitors pop and compare them while also checking line/frame timing.
module tb_tp_video_source;

    localparam int unsigned DW = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, en16 = 1'b0;
    logic [1:0]  pat = 2'd0, pat16 = 2'd0;
    logic        busy, busy16;
    logic [15:0] fcnt, fcnt16;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int exp16[$];
    int last_gap = 0;

    tp_video_source_if #(.DATA_W(DW)) bus ();
    tp_video_source_if #(.DATA_W(DW)) bus16 ();

    tp_video_source #(
        .DATA_W(DW), .H_ACTIVE(8), .H_BLANK(2), .V_ACTIVE(3),
        .FV_LEAD(2), .FV_TRAIL(2), .V_BLANK(3), .CONST_VAL(12'h800)
    ) dut (
        .sig_clock(clk), .sig_reset(rst), .sig_en_i(en), .pat_sel(pat),
        .sig_en_o(busy), .frame_cnt(fcnt), .vid(bus)
    );

    tp_video_source #(
        .DATA_W(DW), .H_ACTIVE(16), .H_BLANK(2), .V_ACTIVE(3),
        .FV_LEAD(2), .FV_TRAIL(2), .V_BLANK(3), .CONST_VAL(12'h800)
    ) dut16 (
        .sig_clock(clk), .sig_reset(rst), .sig_en_i(en16), .pat_sel(pat16),
        .sig_en_o(busy16), .frame_cnt(fcnt16), .vid(bus16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int p, input int h, input bit wide);
        int v;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < h; c++) begin
                case (p)
                    0:       v = c & 'hFFF;
                    1:       v = (r + c) & 'hFFF;
                    2:       v = (((c >> 3) ^ (r >> 3)) & 1) ? 'hFFF : 0;
                    default: v = 'h800;
                endcase
                if (wide) exp16.push_back(v);
                else      exp_q.push_back(v);
            end
        end
    endtask

    task automatic wait_idle(input bit wide, input string name);
        int n = 0;
        while ((wide ? busy16 : busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(wide ? busy16 : busy), 0);
    endtask

    task automatic wait_cnt(input int want);
        int n = 0;
        while (int'(fcnt) != want && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("frame_cnt_step", int'(fcnt), want);
    endtask

    task automatic pulse_en();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Main-instance monitor: pixel scoreboard plus line/frame/gap timing.
    int  fv_run = 0, lv_run = 0, low_run = 0;
    bit  fv_prev = 0, lv_prev = 0;
    always @(negedge clk) begin
        if (rst) begin
            fv_run = 0; lv_run = 0; low_run = 0; fv_prev = 0; lv_prev = 0;
        end else begin
            if (bus.oLValid) begin
                check("lvalid_in_fvalid", int'(bus.oFValid), 1);
                if (exp_q.size() == 0) check("unexpected_pixel", int'(bus.odata), -1);
                else check("pixel", int'(bus.odata), exp_q.pop_front());
                lv_run++;
            end else begin
                check("blank_data", int'(bus.odata), 0);
                if (lv_prev) begin
                    check("line_len", lv_run, 8);
                    lv_run = 0;
                end
            end
            if (bus.oFValid) begin
                if (!fv_prev) last_gap = low_run;
                fv_run++;
                low_run = 0;
            end else begin
                if (fv_prev) begin
                    check("frame_fv_len", fv_run, 32);
                    fv_run = 0;
                end
                low_run++;
            end
            fv_prev = bus.oFValid;
            lv_prev = bus.oLValid;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus16.oLValid) begin
            if (exp16.size() == 0) check("unexpected_pixel16", int'(bus16.odata), -1);
            else check("pixel16", int'(bus16.odata), exp16.pop_front());
        end
    end

    initial begin
        int n;
        int rises;
        bit prev;

        // Reset state
        @(negedge clk);
        check("rst_fvalid", int'(bus.oFValid), 0);
        check("rst_lvalid", int'(bus.oLValid), 0);
        check("rst_data", int'(bus.odata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fcnt", int'(fcnt), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single frame, ramp
        pat = 2'd0;
        push_frame(0, 8, 0);
        pulse_en();
        wait_idle(0, "t1_idle");
        check("t1_fcnt", int'(fcnt), 1);
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: back-to-back frames
        push_frame(0, 8, 0);
        push_frame(0, 8, 0);
        push_frame(0, 8, 0);
        en = 1'b1;
        wait_cnt(2);
        wait_cnt(3);
        wait_cnt(4);
        en = 1'b0;
        check("t2_gap", last_gap, 3);
        wait_idle(0, "t2_idle");
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: patterns
        pat = 2'd1;
        push_frame(1, 8, 0);
        pulse_en();
        wait_idle(0, "t3_pat1_idle");
        pat = 2'd3;
        push_frame(3, 8, 0);
        pulse_en();
        wait_idle(0, "t3_pat3_idle");
        check("t3_queue_empty", exp_q.size(), 0);
        pat16 = 2'd2;
        push_frame(2, 16, 1);
        en16 = 1'b1;
        @(negedge clk);
        en16 = 1'b0;
        wait_idle(1, "t3_pat2_idle");
        check("t3_queue16_empty", exp16.size(), 0);
        check("t3_fcnt16", int'(fcnt16), 1);

        // 4: change pat and drop en mid-line
        pat = 2'd1;
        push_frame(1, 8, 0);
        en = 1'b1;
        n = 0;
        while (!bus.oLValid && n < 50) begin @(negedge clk); n++; end
        check("t4_line_start", int'(bus.oLValid), 1);
        repeat (3) @(negedge clk);
        pat = 2'd3;
        en  = 1'b0;
        n = 0;
        while (bus.oFValid && n < 100) begin @(negedge clk); n++; end
        check("t4_fv_fall", int'(bus.oFValid), 0);
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        check("t4_busy_fall_delay", n, 3);
        check("t4_queue_empty", exp_q.size(), 0);

        // 5: reset during the second line
        pat = 2'd0;
        push_frame(0, 8, 0);
        en = 1'b1;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 200 && rises < 2; i++) begin
            @(negedge clk);
            if (bus.oLValid && !prev) rises++;
            prev = bus.oLValid;
        end
        check("t5_second_line", rises, 2);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_fvalid", int'(bus.oFValid), 0);
        check("t5_rst_lvalid", int'(bus.oLValid), 0);
        check("t5_rst_data", int'(bus.odata), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_fcnt", int'(fcnt), 0);
        exp_q.delete();
        push_frame(0, 8, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!bus.oLValid && n < 50) begin @(negedge clk); n++; end
        check("t5_restart_line", int'(bus.oLValid), 1);
        en = 1'b0;
        wait_idle(0, "t5_idle");
        check("t5_fcnt", int'(fcnt), 1);
        check("t5_queue_empty", exp_q.size(), 0);

        // 6: frame counter wrap
        push_frame(0, 8, 0);
        pulse_en();
        n = 0;
        while (!bus.oFValid && n < 20) begin @(negedge clk); n++; end
        check("t6_fv_start", int'(bus.oFValid), 1);
        force dut.frame_cnt_q = 16'hFFFF;
        #1 release dut.frame_cnt_q;
        check("t6_preload", int'(fcnt), 'hFFFF);
        wait_idle(0, "t6_idle");
        check("t6_wrap", int'(fcnt), 0);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
